// File: rtl/nano_cpu.sv
// nano_cpu: 16-bit multi-cycle CPU, 16x16 register file, 8-bit PC, shared 256x16 memory bus.
// Define NANO_BRANCH_EN to make opcode 3 a BRZ; otherwise opcode 3 behaves as a NOP.
module nano_cpu #(
  parameter logic [7:0] PC_RESET = 8'h00
) (
  input  logic        ck,
  input  logic        rst,
  output logic [7:0]  address,
  input  logic [15:0] dataR,
  output logic [15:0] dataW,
  output logic        ce,
  output logic        we
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    MEM   = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [3:0] OP_READ  = 4'h0;
  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_JMP   = 4'h2;
  localparam logic [3:0] OP_BRZ   = 4'h3;
  localparam logic [3:0] OP_ADD   = 4'h4;
  localparam logic [3:0] OP_SUB   = 4'h5;
  localparam logic [3:0] OP_AND   = 4'h6;
  localparam logic [3:0] OP_OR    = 4'h7;
  localparam logic [3:0] OP_INC   = 4'h8;
  localparam logic [3:0] OP_DEC   = 4'h9;
  localparam logic [3:0] OP_XOR   = 4'hA;
  localparam logic [3:0] OP_NOT   = 4'hB;
  localparam logic [3:0] OP_SHL   = 4'hC;
  localparam logic [3:0] OP_SHR   = 4'hD;
  localparam logic [3:0] OP_NOP   = 4'hE;
  localparam logic [3:0] OP_HALT  = 4'hF;

  state_t      state;
  state_t      state_next;
  logic [7:0]  pc;
  logic [7:0]  pc_next;
  logic [15:0] ir;
  logic [15:0] ir_next;
  logic [15:0] regs [16];

  logic [3:0]  op;
  logic [3:0]  ra;
  logic [3:0]  rb;
  logic [3:0]  rc;
  logic [7:0]  addr;
  logic [15:0] rb_val;
  logic [15:0] rc_val;
  logic [15:0] alu;

  logic        rf_we;
  logic [3:0]  rf_idx;
  logic [15:0] rf_data;

  assign op     = ir[15:12];
  assign ra     = ir[11:8];
  assign rb     = ir[7:4];
  assign rc     = ir[3:0];
  assign addr   = ir[11:4];
  assign rb_val = regs[rb];
  assign rc_val = regs[rc];

  // Operands come from the old register values, so ra may equal rb or rc.
  always_comb begin
    alu = '0;
    case (op)
      OP_ADD:  alu = rb_val + rc_val;
      OP_SUB:  alu = rb_val - rc_val;
      OP_AND:  alu = rb_val & rc_val;
      OP_OR:   alu = rb_val | rc_val;
      OP_INC:  alu = rb_val + 16'd1;
      OP_DEC:  alu = rb_val - 16'd1;
      OP_XOR:  alu = rb_val ^ rc_val;
      OP_NOT:  alu = ~rb_val;
      OP_SHL:  alu = {rb_val[14:0], 1'b0};
      OP_SHR:  alu = {1'b0, rb_val[15:1]};
      default: alu = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    ir_next    = ir;
    rf_we      = 1'b0;
    rf_idx     = ra;
    rf_data    = alu;
    unique case (state)
      FETCH: begin
        ir_next    = dataR;
        pc_next    = pc + 8'd1;
        state_next = EXEC;
      end
      EXEC: begin
        state_next = FETCH;
        case (op)
          OP_READ,
          OP_WRITE: state_next = MEM;
          OP_JMP:   pc_next = addr;
          OP_BRZ: begin
`ifdef NANO_BRANCH_EN
            if (rc_val == 16'd0) pc_next = addr;
`else
            pc_next = pc;
`endif
          end
          OP_NOP:   pc_next = pc;
          OP_HALT:  state_next = HALT;
          default:  rf_we = 1'b1;
        endcase
      end
      MEM: begin
        state_next = FETCH;
        if (op == OP_READ) begin
          rf_we   = 1'b1;
          rf_idx  = rc;
          rf_data = dataR;
        end
      end
      HALT: state_next = HALT;
    endcase
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state <= FETCH;
      pc    <= PC_RESET;
      ir    <= '0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      ir    <= ir_next;
      if (rf_we) regs[rf_idx] <= rf_data;
    end
  end

  // Reset gates the bus combinationally so an aborted WRITE never shows we=1.
  always_comb begin
    address = pc;
    ce      = 1'b0;
    we      = 1'b0;
    dataW   = rc_val;
    if (rst) begin
      address = PC_RESET;
      dataW   = '0;
    end else begin
      unique case (state)
        FETCH: ce = 1'b1;
        EXEC:  ce = 1'b0;
        MEM: begin
          address = addr;
          ce      = 1'b1;
          we      = (op == OP_WRITE);
        end
        HALT:  ce = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_nano_cpu.sv
// Bench for nano_cpu: instruction-level reference model predicts bus activity cycle by cycle.
module tb_nano_cpu;

  localparam logic [7:0] PC_RST = 8'h00;

  logic        ck;
  logic        rst;
  logic [7:0]  address;
  logic [15:0] dataR;
  logic [15:0] dataW;
  logic        ce;
  logic        we;

  nano_cpu #(.PC_RESET(PC_RST)) dut (
    .ck      (ck),
    .rst     (rst),
    .address (address),
    .dataR   (dataR),
    .dataW   (dataW),
    .ce      (ce),
    .we      (we)
  );

  // ---------------- clock / memory ----------------
  initial ck = 1'b0;
  always #5 ck = ~ck;

  logic [15:0] mem [256];
  logic [15:0] img [256];
  logic        ld;

  always @(posedge ck) begin
    if (ld) for (int i = 0; i < 256; i++) mem[i] <= img[i];
    else if (we) mem[address] <= dataW;
  end
  assign dataR = mem[address];

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [23:0] exp_q[$];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge ck) begin
    if (rst === 1'b0 && we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("write_unexpected", 16'(exp_q.size()), 16'd1);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        check("write_addr", 16'(address), 16'(e[23:16]));
        check("write_data", dataW, e[15:0]);
      end
    end
  end

  // ---------------- reference model ----------------
  logic [15:0] m_regs [16];
  logic [15:0] m_mem  [256];
  logic [7:0]  m_pc;
  logic        m_halted;

  task automatic model_init();
    for (int i = 0; i < 256; i++) m_mem[i] = img[i];
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_pc     = PC_RST;
    m_halted = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge ck);
    rst = 1'b1;
    ld  = 1'b1;
    @(posedge ck);
    #1 ld = 1'b0;
    @(negedge ck);
    #1;
    check("rst_address", 16'(address), 16'(PC_RST));
    check("rst_ce", 16'(ce), 16'd0);
    check("rst_we", 16'(we), 16'd0);
    check("rst_dataw", dataW, 16'd0);
    rst = 1'b0;
    model_init();
  endtask

  task automatic chk_cycle(input string tag, input logic [7:0] a, input logic c, input logic w,
                           input logic chk_a, input logic chk_d, input logic [15:0] d);
    #1;
    if (chk_a) check({tag, "_address"}, 16'(address), 16'(a));
    check({tag, "_ce"}, 16'(ce), 16'(c));
    check({tag, "_we"}, 16'(we), 16'(w));
    if (chk_d) check({tag, "_dataw"}, dataW, d);
    @(negedge ck);
  endtask

  // Executes one instruction on the model and checks every bus cycle it should take.
  task automatic step_one();
    logic [15:0] ir;
    logic [3:0]  op, ra, rb, rc;
    logic [7:0]  ad;
    logic [15:0] b, c;
    ir = m_mem[m_pc];
    op = ir[15:12];
    ra = ir[11:8];
    rb = ir[7:4];
    rc = ir[3:0];
    ad = ir[11:4];
    chk_cycle("fetch", m_pc, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0);
    m_pc = m_pc + 8'd1;
    b = m_regs[rb];
    c = m_regs[rc];
    if (op == 4'h1) exp_q.push_back({ad, c});
    chk_cycle("exec", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    case (op)
      4'h0: begin
        chk_cycle("read", ad, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0);
        m_regs[rc] = m_mem[ad];
      end
      4'h1: begin
        chk_cycle("write", ad, 1'b1, 1'b1, 1'b1, 1'b1, c);
        m_mem[ad] = c;
      end
      4'h2: m_pc = ad;
      4'h3: begin
`ifdef NANO_BRANCH_EN
        if (c == 16'd0) m_pc = ad;
`endif
      end
      4'h4: m_regs[ra] = b + c;
      4'h5: m_regs[ra] = b - c;
      4'h6: m_regs[ra] = b & c;
      4'h7: m_regs[ra] = b | c;
      4'h8: m_regs[ra] = b + 16'd1;
      4'h9: m_regs[ra] = b - 16'd1;
      4'hA: m_regs[ra] = b ^ c;
      4'hB: m_regs[ra] = ~b;
      4'hC: m_regs[ra] = b << 1;
      4'hD: m_regs[ra] = b >> 1;
      4'hF: begin
        m_halted = 1'b1;
        repeat (4) chk_cycle("halt", m_pc, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
      end
      default: ;
    endcase
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    ld  = 1'b0;
    for (int i = 0; i < 256; i++) img[i] = 16'hE000;

    // Directed program: read, write, jumps, ALU chain, branch, PC wrap.
    img[8'h00] = 16'h4000;
    img[8'h01] = 16'h0093;
    img[8'h02] = 16'h1103;
    img[8'h03] = 16'h2080;
    img[8'h05] = 16'hE000;
    img[8'h06] = 16'h2FF0;
    img[8'h08] = 16'h2140;
    img[8'h09] = 16'h000A;
    img[8'h14] = 16'h8110;
    img[8'h15] = 16'h8221;
    img[8'h16] = 16'h4312;
    img[8'h17] = 16'h9440;
    img[8'h18] = 16'h1114;
    img[8'h19] = 16'h3050;
    img[8'h1A] = 16'h2FF0;
    img[8'hFF] = 16'hE000;
    do_reset();
    repeat (15) step_one();
    check("dir_mem10", mem[8'h10], 16'h000A);
    check("dir_mem11", mem[8'h11], 16'hFFFF);
    check("dir_write_q_drain", 16'(exp_q.size()), 16'd0);

    // Reset arriving in the MEM cycle of a WRITE must suppress the write.
    for (int i = 0; i < 256; i++) img[i] = 16'hE000;
    img[8'h00] = 16'h8330;
    img[8'h01] = 16'h1103;
    img[8'h10] = 16'h5A5A;
    do_reset();
    step_one();
    chk_cycle("abort_fetch", 8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0);
    chk_cycle("abort_exec", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    rst = 1'b1;
    #1;
    check("abort_we", 16'(we), 16'd0);
    check("abort_ce", 16'(ce), 16'd0);
    check("abort_address", 16'(address), 16'(PC_RST));
    @(posedge ck);
    #1;
    check("abort_mem10", mem[8'h10], 16'h5A5A);
    @(negedge ck);
    rst = 1'b0;
    #1;
    check("abort_refetch_address", 16'(address), 16'(PC_RST));
    check("abort_refetch_ce", 16'(ce), 16'd1);

    // HALT holds the bus idle until reset.
    for (int i = 0; i < 256; i++) img[i] = 16'hE000;
    img[8'h00] = 16'hF000;
    do_reset();
    step_one();
    for (int i = 0; i < 20; i++) chk_cycle("halt_hold", 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);

    // Random programs; HALT is made rare so programs run long enough.
    for (int p = 0; p < 30; p++) begin
      for (int i = 0; i < 256; i++) begin
        logic [15:0] w;
        w = 16'($urandom_range(0, 65535));
        if (w[15:12] == 4'hF && $urandom_range(0, 7) != 0) w[15:12] = 4'hE;
        img[i] = w;
      end
      do_reset();
      for (int k = 0; k < 40; k++) begin
        if (!m_halted) step_one();
      end
      check("rnd_write_q_drain", 16'(exp_q.size()), 16'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
